// File: rtl/i2c_rtc_target.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_rtc_target
//  Purpose  : I2C target emulating the PCF8563 register map (16 x 8 bit).
//             Registers 0x02..0x08 double as a host-loadable RTC shadow.
//             SCL is only observed; SDA is pulled low through sda_oe.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_rtc_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h51,
    parameter int         FILTER_LEN = 3
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic        rtc_load,
    input  logic [55:0] rtc_in,
    output logic [55:0] rtc,
    output logic        rtc_updated,
    output logic        busy
);

    localparam int                   c_fcnt_w = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_fcnt_w-1:0]  c_flast  = c_fcnt_w'(FILTER_LEN - 1);

    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_addr     = 4'd1;
    localparam logic [3:0] c_st_addr_ack = 4'd2;
    localparam logic [3:0] c_st_ptr      = 4'd3;
    localparam logic [3:0] c_st_wr       = 4'd4;
    localparam logic [3:0] c_st_rx_ack   = 4'd5;
    localparam logic [3:0] c_st_rd       = 4'd6;
    localparam logic [3:0] c_st_rd_ack   = 4'd7;
    localparam logic [3:0] c_st_wait     = 4'd8;

    // ------------------------------------------------------------------
    // Input conditioning: bit 1 = SCL, bit 0 = SDA. Bus idles high, so
    // everything resets to 1 to avoid a false edge after reset.
    // ------------------------------------------------------------------
    logic [1:0] r_meta, r_sync, r_filt_d;
    logic [1:0] w_filt;

    // Two-flop synchronizer on both pins
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_meta <= 2'b11;
            r_sync <= 2'b11;
        end else begin
            r_meta <= {scl_in, sda_in};
            r_sync <= r_meta;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic                r_lvl;
            logic [c_fcnt_w-1:0] r_cnt;

            // Accept a new level only after FILTER_LEN consecutive equal samples
            always_ff @(posedge mclk) begin
                if (reset) begin
                    r_lvl <= 1'b1;
                    r_cnt <= '0;
                end else if (r_sync[gi] != r_lvl) begin
                    if (r_cnt == c_flast) begin
                        r_lvl <= r_sync[gi];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_fcnt_w'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_filt[gi] = r_lvl;
        end
    endgenerate

    // Previous filtered levels for edge detection
    always_ff @(posedge mclk) begin
        if (reset) r_filt_d <= 2'b11;
        else       r_filt_d <= w_filt;
    end

    logic w_scl_f, w_sda_f, w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_f    = w_filt[1];
    assign w_sda_f    = w_filt[0];
    assign w_scl_rise =  w_scl_f & ~r_filt_d[1];
    assign w_scl_fall = ~w_scl_f &  r_filt_d[1];
    assign w_start    =  r_filt_d[0] & ~w_sda_f & w_scl_f & r_filt_d[1];
    assign w_stop     = ~r_filt_d[0] &  w_sda_f & w_scl_f & r_filt_d[1];

    // ------------------------------------------------------------------
    // Protocol state and register file
    // ------------------------------------------------------------------
    logic [3:0]  r_state, w_state_nx;
    logic [3:0]  r_cnt,   w_cnt_nx;
    logic [7:0]  r_shift, w_shift_nx;
    logic [3:0]  r_ptr,   w_ptr_nx;
    logic        r_oe,    w_oe_nx;
    logic        r_busy,  w_busy_nx;
    logic        r_rw,    w_rw_nx;
    logic        r_mack,  w_mack_nx;
    logic        r_wr_time, w_wr_time_nx;
    logic        w_reg_we;
    logic [7:0]  r_regs [16];
    logic        r_pend;
    logic [55:0] r_pend_data;
    logic        r_upd;
    logic        w_host_we;
    logic [55:0] w_host_data;
    logic [3:0]  w_ptr_inc;
    logic [7:0]  w_rd_cur, w_rd_next;

    assign w_ptr_inc = r_ptr + 4'd1;
    assign w_rd_cur  = r_regs[r_ptr];
    assign w_rd_next = r_regs[w_ptr_inc];

    // State register
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_cnt     <= 4'd0;
            r_shift   <= 8'h00;
            r_ptr     <= 4'd0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_rw      <= 1'b0;
            r_mack    <= 1'b1;
            r_wr_time <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_shift   <= w_shift_nx;
            r_ptr     <= w_ptr_nx;
            r_oe      <= w_oe_nx;
            r_busy    <= w_busy_nx;
            r_rw      <= w_rw_nx;
            r_mack    <= w_mack_nx;
            r_wr_time <= w_wr_time_nx;
        end
    end

    // Next-state logic: bus conditions first, then bit-level protocol
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_shift_nx   = r_shift;
        w_ptr_nx     = r_ptr;
        w_oe_nx      = r_oe;
        w_busy_nx    = r_busy;
        w_rw_nx      = r_rw;
        w_mack_nx    = r_mack;
        w_wr_time_nx = r_wr_time;
        w_reg_we     = 1'b0;

        if (w_stop) begin
            w_state_nx   = c_st_idle;
            w_oe_nx      = 1'b0;
            w_busy_nx    = 1'b0;
            w_wr_time_nx = 1'b0;
        end else if (w_start) begin
            w_state_nx   = c_st_addr;
            w_cnt_nx     = 4'd0;
            w_oe_nx      = 1'b0;
            w_busy_nx    = 1'b1;
            w_wr_time_nx = 1'b0;
        end else begin
            case (r_state)
                c_st_addr, c_st_ptr, c_st_wr: begin
                    if (w_scl_rise && r_cnt != 4'd8) begin
                        w_shift_nx = {r_shift[6:0], w_sda_f};
                        w_cnt_nx   = r_cnt + 4'd1;
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        if (r_state == c_st_addr) begin
                            if (r_shift[7:1] == SLAVE_ADDR) begin
                                w_rw_nx    = r_shift[0];
                                w_oe_nx    = 1'b1;
                                w_state_nx = c_st_addr_ack;
                            end else begin
                                w_state_nx = c_st_idle;
                            end
                        end else if (r_state == c_st_ptr) begin
                            w_ptr_nx   = r_shift[3:0];
                            w_oe_nx    = 1'b1;
                            w_state_nx = c_st_rx_ack;
                        end else begin
                            w_reg_we = 1'b1;
                            w_ptr_nx = w_ptr_inc;
                            if (r_ptr >= 4'd2 && r_ptr <= 4'd8) w_wr_time_nx = 1'b1;
                            w_oe_nx    = 1'b1;
                            w_state_nx = c_st_rx_ack;
                        end
                    end
                end
                c_st_addr_ack: begin
                    if (w_scl_fall) begin
                        w_cnt_nx = 4'd0;
                        if (r_rw) begin
                            w_shift_nx = w_rd_cur;
                            w_oe_nx    = ~w_rd_cur[7];
                            w_state_nx = c_st_rd;
                        end else begin
                            w_oe_nx    = 1'b0;
                            w_state_nx = c_st_ptr;
                        end
                    end
                end
                c_st_rx_ack: begin
                    if (w_scl_fall) begin
                        w_oe_nx    = 1'b0;
                        w_cnt_nx   = 4'd0;
                        w_state_nx = c_st_wr;
                    end
                end
                c_st_rd: begin
                    if (w_scl_rise && r_cnt != 4'd8) begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_oe_nx    = 1'b0;
                            w_state_nx = c_st_rd_ack;
                        end else begin
                            w_shift_nx = {r_shift[6:0], 1'b0};
                            w_oe_nx    = ~r_shift[6];
                        end
                    end
                end
                c_st_rd_ack: begin
                    if (w_scl_rise) begin
                        w_mack_nx = w_sda_f;
                    end else if (w_scl_fall) begin
                        w_ptr_nx = w_ptr_inc;
                        if (!r_mack) begin
                            w_shift_nx = w_rd_next;
                            w_oe_nx    = ~w_rd_next[7];
                            w_cnt_nx   = 4'd0;
                            w_state_nx = c_st_rd;
                        end else begin
                            w_oe_nx    = 1'b0;
                            w_state_nx = c_st_wait;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Host load goes straight in when idle, otherwise is deferred to STOP
    assign w_host_we   = (rtc_load & ~r_busy) | (w_stop & (r_pend | rtc_load));
    assign w_host_data = rtc_load ? rtc_in : r_pend_data;

    // Register file: master writes, then host load on top (host wins at STOP)
    always_ff @(posedge mclk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= 8'h00;
        end else begin
            if (w_reg_we) r_regs[r_ptr] <= r_shift;
            if (w_host_we) begin
                for (int i = 0; i < 7; i++) r_regs[2 + i] <= w_host_data[55 - 8*i -: 8];
            end
        end
    end

    // Pending host load and end-of-transaction update pulse
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_pend      <= 1'b0;
            r_pend_data <= 56'h0;
            r_upd       <= 1'b0;
        end else begin
            r_upd <= w_stop & r_wr_time;
            if (w_stop) begin
                r_pend <= 1'b0;
            end else if (rtc_load && r_busy) begin
                r_pend      <= 1'b1;
                r_pend_data <= rtc_in;
            end
        end
    end

    // Outputs
    always_comb begin
        sda_oe      = r_oe;
        busy        = r_busy;
        rtc_updated = r_upd;
        rtc         = {r_regs[2], r_regs[3], r_regs[4], r_regs[5],
                       r_regs[6], r_regs[7], r_regs[8]};
    end

endmodule
`default_nettype wire

// File: doc/i2c_rtc_target.md
Name: i2c_rtc_target

Overview:
- I2C responder (target) that emulates the PCF8563 register map at 7-bit address 0x51 (write 0xA2, read 0xA3).
- Lets the core's I2C RTC master be exercised in simulation and on boards with no RTC chip fitted.
- Also serves as a soft RTC shadow: the host loads time values into it and reads back anything an I2C master writes.
- Sits on the open-drain SCL/SDA pair. The top level builds the tri-state buffer from sda_oe.

Parameters:
- SLAVE_ADDR, 7'h51, 7-bit target address matched against the first byte after START.
- FILTER_LEN, 3, number of consecutive equal mclk samples needed to accept a new SCL/SDA level (glitch filter).

Ports:
- mclk  in  1  system clock; must be at least 16x the SCL frequency.
- reset  in  1  synchronous, active-high.
- scl_in  in  1  raw SCL pin level.
- sda_in  in  1  raw SDA pin level.
- sda_oe  out  1  1 = pull SDA low; 0 = release (hi-Z). SCL is never driven (no clock stretching).
- rtc_load  in  1  one-cycle pulse: load rtc_in into registers 0x02..0x08.
- rtc_in  in  56  {sec,min,hour,day,wday,cmonth,year}, bits [55:48] = sec → reg 0x02.
- rtc  out  56  registers 0x02..0x08 packed in the same order; continuously valid.
- rtc_updated  out  1  one-cycle pulse after STOP when the master wrote any of 0x02..0x08.
- busy  out  1  1 from accepted START to STOP.

Behaviour:
- Reset values:
  - sda_oe=0, busy=0, rtc_updated=0, rtc=0.
  - All 16 registers = 0x00; pointer = 0; state = IDLE; load_pending = 0.
- Input conditioning:
  - 2-flop synchronizer, then FILTER_LEN filter, giving scl_f/sda_f.
  - Edges are detected on the filtered signals. Latency from pin to edge is 2+FILTER_LEN mclk.
- Bus conditions:
  - START / repeated START: sda_f falls while scl_f = 1. STOP: sda_f rises while scl_f = 1.
  - START from any state → ADDR, bit counter = 0, sda_oe = 0, busy = 1.
  - STOP from any state → IDLE, sda_oe = 0, busy = 0.
- Bit timing:
  - The target samples sda_f on scl_f rising edges.
  - It changes sda_oe only on scl_f falling edges, in the same mclk cycle as the edge is detected.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits, MSB first. On the 8th falling edge:
    - addr[7:1] = SLAVE_ADDR → sda_oe=1, go to ADDR_ACK.
    - No match → IDLE; never drive the bus.
  - ADDR_ACK: on the next falling edge, release SDA.
    - R/W = 0 → PTR.
    - R/W = 1 → load register[pointer] into the shift register, drive its MSB, go to RD.
  - PTR: receive 8 bits, then ACK. pointer = byte[3:0]; upper bits ignored. → WR.
  - WR: receive 8 bits, then ACK.
    - register[pointer] = byte; pointer = pointer+1 mod 16.
    - Writing 0x02..0x08 sets the wr_time flag.
  - RD: drive 8 bits, then release SDA for the master ACK bit.
    - Sample ACK on the rising edge.
    - ACK (0): pointer = pointer+1 mod 16, drive the next byte, stay in RD.
    - NACK (1): pointer = pointer+1 mod 16, go to IDLE-wait (only START/STOP accepted, SDA released).
- Pointer and repeated START:
  - The pointer is not reset by START.
  - A write of the pointer followed by repeated START + read returns data from that pointer.
  - Wrap: pointer 0x0F → 0x00.
- rtc_updated:
  - Pulses one mclk cycle after STOP is detected, if wr_time was set. wr_time is cleared at START.
- Host load:
  - rtc_load with busy = 0 writes 0x02..0x08 in the same cycle.
  - rtc_load with busy = 1 latches rtc_in and sets load_pending. The load is applied on the cycle STOP is detected.
  - If the master also wrote the time registers in that transaction, the pending host load overwrites them and rtc_updated is still pulsed.
  - A second rtc_load while a load is pending replaces the latched value.
- rtc output: updates the cycle after any register write.
- Reset mid-transfer: immediate IDLE, SDA released. The register file returns to 0.

Test Plan:
- Host load: rtc_load with rtc_in=56'h30_15_12_07_03_04_24, then master writes 0xA2,0x02, Sr, 0xA3, reads 7 bytes, NACK, STOP → bytes 30 15 12 07 03 04 24, ACK after 0xA2/0x02/0xA3 (sda_oe=1 for exactly the 9th clock), NACK ends with SDA released.
- Master write: 0xA2,0x02,0x59,0x59,0x23 then STOP → rtc[55:32]=24'h595923; rtc_updated one pulse; busy 1→0 at STOP.
- Wrong address: 0xA4 → sda_oe stays 0 for the entire transfer; no register change.
- Wrap: pointer 0x0F, write 0xAA,0xBB → reg 0x0F=AA, reg 0x00=BB; read from 0x0F returns AA, BB.
- Collision: rtc_load (seconds=0x11) during a master write of 0x45 to reg 0x02 → after STOP, rtc[55:48]=0x11 and rtc_updated pulses once.
- Robustness: 1-mclk glitch on SCL mid-byte is ignored (data intact); reset asserted mid-read → sda_oe=0 the next cycle and all registers 0x00.
